// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Sequential multiply-accumulate stage. Unsigned WIDTH-bit operand pairs come in
// over a valid/ready handshake. Each pair is multiplied by a shift-and-add
// datapath, one multiplier bit per cycle, on a WIDTH-bit adder. The product is
// then added into a saturating ACC_WIDTH-bit accumulator. A pair flagged as last
// makes the block present the accumulated value on a second valid/ready
// handshake. Taking that result clears the accumulator.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset; clears all state
//   clear      synchronous accumulator clear, honoured only while idle
//   in_valid   operand pair a/b/in_last is valid
//   in_ready   block can accept an operand pair (combinational, idle state)
//   a, b       unsigned multiplicand / multiplier
//   in_last    this pair closes the accumulation
//   out_valid  out_data holds a final result
//   out_ready  downstream accepts the result
//   out_data   accumulator value (registered); meaningful while out_valid=1
//   overflow   sticky saturation flag for the current accumulation
//
// Timing from the acceptance edge E0:
//   E1..E(WIDTH)  one partial product per edge
//   E(WIDTH+1)    accumulate; afterwards out_valid=1 (last) or in_ready=1
//
// ACC_WIDTH must be at least 2*WIDTH so a single product always fits.
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // WIDTH-bit adder with carry out: the only adder in the multiply path.
  function automatic logic [WIDTH:0] add_w(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    return {1'b0, x} + {1'b0, y};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [WIDTH-1:0]    a_q,         a_d;
  logic [WIDTH-1:0]    b_q,         b_d;
  logic                last_q,      last_d;
  logic [PROD_W-1:0]   prod_q,      prod_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [ACC_WIDTH-1:0] acc_q,      acc_d;
  logic                ovf_q,       ovf_d;
  logic                out_valid_q, out_valid_d;

  // ---------------------------------------------------------------------------
  // Multiply step
  //
  // Before iteration cnt, prod holds a * b[cnt-1:0] < 2^(cnt+WIDTH), so every
  // bit at or above cnt+WIDTH is still zero. Adding (a << cnt) therefore only
  // touches the WIDTH+1 bits starting at cnt: a WIDTH-bit add of the window
  // prod[cnt +: WIDTH] with a, whose carry lands in the known-zero bit above.
  // Nothing above that can see a carry, so no wide adder is needed.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prod_win;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   partial;
  logic [PROD_W-1:0] prod_step;

  always_comb begin
    prod_win  = prod_q[cnt_q +: WIDTH];
    addend    = b_q[cnt_q] ? a_q : '0;
    partial   = add_w(prod_win, addend);
    prod_step = prod_q;
    prod_step[cnt_q +: (WIDTH + 1)] = partial;
  end

  // ---------------------------------------------------------------------------
  // Accumulate step: one extra bit catches the carry that signals saturation.
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH:0] acc_sum;

  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts from its current value so no branch leaves a
    // signal unassigned; that is what keeps this block free of latches.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        // A clear on the same edge as an acceptance wipes the old total, so
        // the new pair accumulates from zero.
        if (clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          last_d  = in_last;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end

      MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ACC;
        end
      end

      ACC: begin
        // A saturated total stays at all ones: any further nonzero product
        // carries out again and re-saturates.
        if (acc_sum[ACC_WIDTH]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
        end
        if (last_q) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          state_d     = IDLE;
        end
      end

      HOLD: begin
        // Result, flag and valid stay frozen until downstream takes them.
        if (out_ready) begin
          acc_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the values
      // present before the edge, regardless of statement order.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Directed bench for mac_accumulator. Stimulus pushes the hand-computed result
// of each closing pair into a scoreboard queue; a monitor pops and compares
// whenever a result handshake is seen on the output side.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 20;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          clear     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a         = '0;
  logic [W-1:0]  b         = '0;
  logic          in_last   = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic          overflow;

  mac_accumulator #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_result(input logic [31:0] data, input logic ovf);
    exp_t e;
    e.data = data;
    e.ovf  = ovf;
    sb_q.push_back(e);
  endtask

  // Monitor: a result handshake is valid&&ready sampled mid-cycle, completing
  // on the following rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL result_unexpected: got out_data=%0d, expected no result", out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_data", out_data, e.data);
        check("result_overflow", overflow, e.ovf);
      end
    end
  end

  // Offer one pair, wait for acceptance, and follow it through the accumulate
  // edge. Returns on the falling edge after E9.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tl, input logic tc, input string tag);
    int guard = 0;
    int lows  = 0;
    @(negedge clk);
    a = ta; b = tb; in_last = tl; clear = tc; in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0; clear = 1'b0; in_last = 1'b0;
      return;
    end
    @(posedge clk);                       // E0
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 9; i++) begin     // between E0..E9
      if (i > 0) @(negedge clk);
      if (!in_ready) lows++;
    end
    check({tag, "_busy_cycles"}, lows, 32'd9);
    @(negedge clk);                       // after E9
    if (tl) check({tag, "_out_valid"}, out_valid, 32'd1);
    else    check({tag, "_in_ready"}, in_ready, 32'd1);
  endtask

  // Wait until the scoreboard is empty, then one more cycle so the result
  // handshake has completed.
  task automatic drain(input string tag);
    int guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_drained"}, sb_q.size(), 32'd0);
    @(negedge clk);
    check({tag, "_acc_cleared"}, out_data, 32'd0);
    check({tag, "_ovf_cleared"}, overflow, 32'd0);
    check({tag, "_valid_low"}, out_valid, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset values while reset is held low.
    #23;
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single product 3*5.
    expect_result(32'd15, 1'b0);
    send(8'd3, 8'd5, 1'b1, 1'b0, "single");
    drain("single");

    // Four 255*255, last on the fourth: 4*65025 = 260100.
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) expect_result(32'd260100, 1'b0);
      send(8'd255, 8'd255, (i == 4), 1'b0, "stream4");
      if (i == 3) check("stream4_partial", out_data, 32'd195075);
    end
    drain("stream4");

    // Saturation: 16*65025 = 1040400 fits, the 17th overflows 2^20-1.
    for (int i = 1; i <= 17; i++) begin
      if (i == 17) expect_result(32'd1048575, 1'b1);
      send(8'd255, 8'd255, (i == 17), 1'b0, "sat");
      if (i == 16) begin
        check("sat_after16_data", out_data, 32'd1040400);
        check("sat_after16_ovf", overflow, 32'd0);
      end
    end
    drain("sat");

    // Back-pressure: result 15 held for 5 cycles while a new pair is offered.
    out_ready = 1'b0;
    expect_result(32'd15, 1'b0);
    send(8'd3, 8'd5, 1'b1, 1'b0, "bp");
    a = 8'd1; b = 8'd1; in_last = 1'b1; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 20'd15 || in_ready !== 1'b0 ||
          overflow !== 1'b0)
        bad++;
    end
    check("bp_stable_cycles_bad", bad, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    drain("bp");
    check("bp_offer_not_taken", in_ready, 32'd1);

    // Reset mid-multiply, with a nonzero total already accumulated.
    send(8'd7, 8'd9, 1'b0, 1'b0, "pre_rst");
    check("pre_rst_acc", out_data, 32'd63);
    @(negedge clk);
    a = 8'd200; b = 8'd200; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(posedge clk);            // E4
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 32'd1);
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_overflow", overflow, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    expect_result(32'd4, 1'b0);
    send(8'd2, 8'd2, 1'b1, 1'b0, "post_rst");
    drain("post_rst");

    // Clear together with a zero pair: old 63 discarded, result 0.
    send(8'd7, 8'd9, 1'b0, 1'b0, "pre_clr");
    check("pre_clr_acc", out_data, 32'd63);
    expect_result(32'd0, 1'b0);
    send(8'd0, 8'd0, 1'b1, 1'b1, "clr_zero");
    drain("clr_zero");

    // Clear alone while idle, then 2*3 closes with 6.
    send(8'd1, 8'd1, 1'b0, 1'b0, "pre_clr2");
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_alone_acc", out_data, 32'd0);
    expect_result(32'd6, 1'b0);
    send(8'd2, 8'd3, 1'b1, 1'b0, "after_clr");
    drain("after_clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage of the MAC unit. It takes unsigned 8-bit operand pairs over a valid/ready handshake and multiplies them with a shift-and-add datapath built on the existing 8-bit adder. Each product is added into a saturating accumulator. When an operand flagged as last has been accumulated, the block presents the accumulated result downstream through a second valid/ready handshake. It sits directly downstream of the 8-bit operand register and consumes that register's output.

## Interface
- WIDTH, 8, operand width in bits (unsigned)
- ACC_WIDTH, 20, accumulator width in bits; must be ≥ 2*WIDTH

- clk  input  1  single clock, rising-edge active
- reset  input  1  asynchronous, active-low; low clears all state immediately
- clear  input  1  synchronous accumulator clear; honoured only in IDLE
- in_valid  input  1  operand pair a/b/in_last is valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- in_last  input  1  this pair closes the accumulation
- out_valid  output  1  out_data holds a final result
- out_ready  input  1  downstream accepts the result
- out_data  output  ACC_WIDTH  accumulator value (registered)
- overflow  output  1  sticky saturation flag for the current accumulation

## Operation
- States: IDLE, MUL, ACC, HOLD.
- IDLE: in_ready=1. in_ready is combinational, (state==IDLE).
  - clear=1: acc←0 and overflow←0 on this edge.
  - in_valid=1: the block latches a, b and in_last, sets prod←0 and cnt←0, then moves to MUL.
  - clear and in_valid together: the clear wins for the old value, so the new pair accumulates from 0.
- MUL: one partial product per cycle.
  - If b_reg[cnt]=1, prod←prod+(a_reg<<cnt). prod is 2*WIDTH bits wide.
  - cnt←cnt+1 each cycle. When cnt==WIDTH-1, the state moves to ACC.
  - in_valid, clear and out_ready are ignored in this state.
- ACC: sum = acc + zero-extended prod, computed at ACC_WIDTH+1 bits.
  - If sum > 2^ACC_WIDTH−1: acc←all ones and overflow←1. Otherwise acc←sum.
  - Next state is HOLD if last_reg=1, otherwise IDLE.
- HOLD: out_valid=1 and out_data=acc, held stable; in_ready=0.
  - out_ready=1 on an edge: acc←0, overflow←0, out_valid←0, state→IDLE.
- out_data always reflects acc. It is guaranteed meaningful only while out_valid=1.
- overflow is sticky from the first saturation until the result is taken or a clear occurs.
- Arithmetic is unsigned throughout. A saturated acc stays at all ones for further adds.

## Timing
- Reset values: state=IDLE, acc=0, out_data=0, out_valid=0, overflow=0, in_ready=1, prod=0, cnt=0.
- Reset asserted mid-operation aborts it immediately and discards the latched operands and partial product. The first edge after reset deasserts behaves as IDLE.
- Edge numbering: the acceptance edge E0 is the edge where in_valid and in_ready are both 1.
  - E1 through E8: the WIDTH multiply iterations.
  - E9: the accumulate step. After E9, out_valid=1 for a last pair, or in_ready=1 otherwise.
- Latency from acceptance edge to out_valid: 9 edges.
- Throughput: one operand pair per 10 cycles, since the earliest next acceptance is E10.
- With out_ready held high, the result handshake completes at E10. The earliest following acceptance is E11.
- Out-side back-pressure: out_valid, out_data and overflow stay constant while out_ready=0. There is no timeout.
- An in_valid asserted while in_ready=0 is not consumed. The upstream register must hold it.

## Test plan
- Single product: after reset, a=3, b=5, in_last=1 → out_valid rises after E9 with out_data=15 and overflow=0; out_ready=1 clears acc to 0.
- Stream of four: four pairs of 255×255, last flag on the 4th → out_data=260100, overflow=0; in_ready is low during each MUL/ACC span of 9 cycles.
- Saturation: 17 pairs of 255×255, last on the 17th → after the 16th pair acc=1040400; final out_data=1048575 and overflow=1; both clear on the out handshake.
- Back-pressure: result 15 pending with out_ready=0 for 5 cycles → out_valid=1, out_data=15 and in_ready=0 are stable throughout; in_valid offered meanwhile is not accepted.
- Reset mid-MUL: reset pulsed low at E4 of 200×200 → all outputs return to reset values at once; next 2×2 with last → out_data=4.
- Clear and zero operands: accumulate 7×9 with no last, then a=0, b=0, in_last=1 with clear=1 on the same edge → out_data=0 and overflow=0.
